rsa_mod_exp: RTL and testbench

RSA_MOD_EXP -- requirements
Module: rsa_mod_exp

---
 rtl/rsa_mod_exp.sv | 127 ++++++++++++
 tb/tb_rsa_mod_exp.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_mod_exp.sv
// Modular exponentiation Output = Input^key mod n: left-to-right square-and-multiply with Blakley multiplies.
// Optional macro RSA_MODEXP_ERR_EN adds an err output and rejects operands with n < 2 or Input >= n.
module rsa_mod_exp #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Input,
    input  logic [WIDTH-1:0] key,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] Output,
    output logic             busy,
    output logic             finish
`ifdef RSA_MODEXP_ERR_EN
    ,
    output logic             err
`endif
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] SQR  = 3'd2;
    localparam logic [2:0] MUL  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]       state;
    logic [WIDTH-1:0] r, b, e, n_reg;
    logic [WIDTH+1:0] p;
    logic [CW-1:0]    bit_cnt, exp_idx;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH+1:0] n_ext, sum, sub1, sub2;

    // One Blakley step: the multiplier is always R, the multiplicand is R (square) or B (multiply).
    always_comb begin
        mcand = (state == MUL) ? b : r;
        n_ext = {2'b00, n_reg};
        sum   = {p[WIDTH:0], 1'b0} + (r[bit_cnt] ? {2'b00, mcand} : '0);
        sub1  = (sum  >= n_ext) ? sum  - n_ext : sum;
        sub2  = (sub1 >= n_ext) ? sub1 - n_ext : sub1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            r       <= '0;
            b       <= '0;
            e       <= '0;
            n_reg   <= '0;
            p       <= '0;
            bit_cnt <= '0;
            exp_idx <= '0;
            Output  <= '0;
            busy    <= 1'b0;
            finish  <= 1'b0;
`ifdef RSA_MODEXP_ERR_EN
            err     <= 1'b0;
`endif
        end else begin
            finish <= 1'b0;
            case (state)
                IDLE: begin
                    // NOTE: finish is still high in the first IDLE cycle; a start there is dropped.
                    if (start && !finish) begin
                        b     <= Input;
                        e     <= key;
                        n_reg <= n;
                        busy  <= 1'b1;
`ifdef RSA_MODEXP_ERR_EN
                        err   <= 1'b0;
`endif
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    r       <= WIDTH'(1);
                    p       <= '0;
                    bit_cnt <= CW'(WIDTH - 1);
                    exp_idx <= CW'(WIDTH - 1);
`ifdef RSA_MODEXP_ERR_EN
                    if (n_reg < WIDTH'(2) || b >= n_reg) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= SQR;
                    end
`else
                    state   <= SQR;
`endif
                end
                SQR, MUL: begin
                    if (bit_cnt == '0) begin
                        r       <= sub2[WIDTH-1:0];
                        p       <= '0;
                        bit_cnt <= CW'(WIDTH - 1);
                        if (state == SQR && e[exp_idx]) begin
                            state <= MUL;
                        end else if (exp_idx == '0) begin
                            state <= DONE;
                        end else begin
                            exp_idx <= exp_idx - 1'b1;
                            state   <= SQR;
                        end
                    end else begin
                        p       <= sub2;
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                DONE: begin
`ifdef RSA_MODEXP_ERR_EN
                    Output <= err ? '0 : r;
`else
                    Output <= r;
`endif
                    finish <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_mod_exp.sv
// Self-checking bench for rsa_mod_exp: cycle-level behavioural model plus directed and random operations.
// Build with RSA_MODEXP_ERR_EN defined to also exercise the operand-check feature.
module tb_rsa_mod_exp;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] in_val, key, n;
    logic [W-1:0] out;
    logic         busy, finish;
`ifdef RSA_MODEXP_ERR_EN
    logic         err;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    rsa_mod_exp #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .Input  (in_val),
        .key    (key),
        .n      (n),
        .Output (out),
        .busy   (busy),
        .finish (finish)
`ifdef RSA_MODEXP_ERR_EN
        ,
        .err    (err)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Right-to-left binary exponentiation on plain integers.
    function automatic longint modexp(input longint base, input longint ex, input longint m);
        longint res, bb;
        if (m == 0) return 0;
        res = 1 % m;
        bb  = base % m;
        while (ex > 0) begin
            if (ex[0]) res = (res * bb) % m;
            bb = (bb * bb) % m;
            ex = ex >> 1;
        end
        return res;
    endfunction

    // Behavioural model: what busy/finish/Output/err must be after each edge.
    bit           m_busy, m_finish, m_was_fin, m_err, m_err_pending;
    logic [W-1:0] m_out, m_pending;
    int           m_cnt, m_target;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_busy = 0; m_finish = 0; m_out = '0; m_err = 0; m_cnt = 0;
        end else begin
            m_was_fin = m_finish;
            m_finish  = 0;
            if (m_busy) begin
                m_cnt++;
                if (m_cnt == m_target) begin
                    m_finish = 1;
                    m_busy   = 0;
                    m_out    = m_pending;
                    m_err    = m_err_pending;
                end
            end else if (start && !m_was_fin) begin
                m_busy = 1;
                m_cnt  = 0;
                m_err  = 0;
`ifdef RSA_MODEXP_ERR_EN
                if (n < 2 || in_val >= n) begin
                    m_target      = 2;
                    m_pending     = '0;
                    m_err_pending = 1;
                end else
`endif
                begin
                    m_target      = 2 + W * (W + $countones(key));
                    m_pending     = W'(modexp(longint'(in_val), longint'(key), longint'(n)));
                    m_err_pending = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en && !rst) begin
            check("busy", busy, m_busy);
            check("finish", finish, m_finish);
            check("output", out, m_out);
`ifdef RSA_MODEXP_ERR_EN
            check("err", err, m_err);
`endif
        end
    end

    // Launch one operation; start is sampled at edge 0, edges counts up to the finish edge.
    task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] k, input logic [W-1:0] m,
                          input int repulse, output int edges);
        @(negedge clk);
        in_val = b; key = k; n = m; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        in_val = W'($urandom); key = W'($urandom); n = W'($urandom);
        edges  = 0;
        while (edges < 1000) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = 1'b0;
            if (finish) break;
            if (edges + 1 == repulse) start = 1'b1;
        end
        start = 1'b0;
        if (!finish) check("finish_timeout", finish, 1);
    endtask

    // Start during the finish cycle must be dropped.
    task automatic poke_in_finish_cycle();
        start = 1'b1; in_val = 16'd7; key = 16'd3; n = 16'd101;
        @(negedge clk);
        start = 1'b0;
        check("finish_cycle_start_ignored", busy, 0);
    endtask

    initial begin
        int ed;
        logic [W-1:0] rn, rb, rk;
        rst = 1'b1; start = 1'b0; in_val = '0; key = '0; n = '0;
        repeat (3) @(negedge clk);
        check("rst_output", out, 0);
        check("rst_busy", busy, 0);
        check("rst_finish", finish, 0);
        rst = 1'b0;
        cmp_en = 1'b1;

        check("model_enc", modexp(11, 5, 3551), 1256);
        check("model_dec", modexp(1256, 1373, 3551), 11);

        run_op(16'd11, 16'd5, 16'd3551, 0, ed);
        check("enc_latency", ed, 290);
        check("enc_output", out, 1256);
        poke_in_finish_cycle();

        run_op(16'd1256, 16'd1373, 16'd3551, 0, ed);
        check("dec_latency", ed, 370);
        check("dec_output", out, 11);

        run_op(16'd11, 16'd0, 16'd3551, 0, ed);
        check("key0_latency", ed, 258);
        check("key0_output", out, 1);

        run_op(16'd11, 16'd1, 16'd3551, 0, ed);
        check("key1_latency", ed, 274);
        check("key1_output", out, 11);

        run_op(16'd11, 16'd5, 16'd3551, 100, ed);
        check("repulse_latency", ed, 290);
        check("repulse_output", out, 1256);

        // Reset in the middle of an operation.
        @(negedge clk);
        in_val = 16'd1256; key = 16'd1373; n = 16'd3551; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (149) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_output", out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_finish", finish, 0);
        repeat (3) begin
            @(negedge clk);
            check("rst_held_finish", finish, 0);
        end
        rst = 1'b0;
        repeat (400) @(negedge clk);
        run_op(16'd11, 16'd5, 16'd3551, 0, ed);
        check("post_rst_latency", ed, 290);
        check("post_rst_output", out, 1256);

        for (int i = 0; i < 12; i++) begin
            rn = W'($urandom_range(65535, 2));
            rb = W'($urandom_range(int'(rn) - 1, 0));
            rk = W'($urandom);
            run_op(rb, rk, rn, int'($urandom_range(400, 1)), ed);
            check("rnd_latency", ed, 2 + W * (W + $countones(rk)));
            check("rnd_output", out, modexp(longint'(rb), longint'(rk), longint'(rn)));
            if (i % 3 == 0) poke_in_finish_cycle();
        end

`ifdef RSA_MODEXP_ERR_EN
        run_op(16'd11, 16'd5, 16'd1, 0, ed);
        check("err_n1_latency", ed, 2);
        check("err_n1_flag", err, 1);
        check("err_n1_output", out, 0);
        run_op(16'd4000, 16'd5, 16'd3551, 0, ed);
        check("err_big_latency", ed, 2);
        check("err_big_flag", err, 1);
        check("err_big_output", out, 0);
        run_op(16'd11, 16'd5, 16'd3551, 0, ed);
        check("err_ok_flag", err, 0);
        check("err_ok_output", out, 1256);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
